// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared miniGPU core-state constants and fetcher state encoding
package gpu_pkg;

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    FETCHING = 3'b001,
    FETCHED  = 3'b010
  } fetcher_state_e;

endpackage

// File: rtl/fetch_icache.sv
// rtl/fetch_icache.sv - direct-mapped instruction cache: combinational lookup, single-line fill, global flush
module fetch_icache #(
  parameter int ADDR_BITS   = 8,
  parameter int INSTR_BITS  = 16,
  parameter int CACHE_LINES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_BITS-1:0]  lookup_addr,
  output logic                  hit,
  output logic [INSTR_BITS-1:0] hit_data,
  input  logic                  fill_en,
  input  logic [ADDR_BITS-1:0]  fill_addr,
  input  logic [INSTR_BITS-1:0] fill_data,
  input  logic                  flush
);

  localparam int INDEX_BITS = $clog2(CACHE_LINES);
  localparam int TAG_BITS   = ADDR_BITS - INDEX_BITS;

  logic [CACHE_LINES-1:0] valid_q;
  logic [TAG_BITS-1:0]    tag_q  [CACHE_LINES];
  logic [INSTR_BITS-1:0]  data_q [CACHE_LINES];

  logic [INDEX_BITS-1:0] lookup_idx;
  logic [TAG_BITS-1:0]   lookup_tag;
  logic [INDEX_BITS-1:0] fill_idx;

  assign lookup_idx = lookup_addr[INDEX_BITS-1:0];
  assign lookup_tag = lookup_addr[ADDR_BITS-1:INDEX_BITS];
  assign fill_idx   = fill_addr[INDEX_BITS-1:0];

  // A pending flush already invalidates everything, so a same-cycle lookup must miss.
  assign hit      = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag) && !flush;
  assign hit_data = data_q[lookup_idx];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset; the valid bit alone qualifies them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_addr[ADDR_BITS-1:INDEX_BITS];
      data_q[fill_idx] <= fill_data;
    end
  end

endmodule

// File: rtl/instr_fetcher.sv
// rtl/instr_fetcher.sv - instruction fetcher for the miniGPU core; optional cache under INSTR_FETCHER_CACHE_EN
module instr_fetcher
  import gpu_pkg::*;
#(
  parameter int ADDR_BITS   = 8,
  parameter int INSTR_BITS  = 16,
  parameter int CACHE_LINES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            core_state,
  input  logic [ADDR_BITS-1:0]  current_pc,
  input  logic                  cache_flush,
  output logic                  mem_read_valid,
  output logic [ADDR_BITS-1:0]  mem_read_address,
  input  logic                  mem_read_ready,
  input  logic [INSTR_BITS-1:0] mem_read_data,
  output logic [2:0]            fetcher_state,
  output logic [INSTR_BITS-1:0] instruction
);

  fetcher_state_e        state_q, state_d;
  logic                  valid_d;
  logic [ADDR_BITS-1:0]  addr_d;
  logic [INSTR_BITS-1:0] instr_d;
  logic                  fill_en;
  logic                  cache_hit;
  logic [INSTR_BITS-1:0] cache_hit_data;

`ifdef INSTR_FETCHER_CACHE_EN
  fetch_icache #(
    .ADDR_BITS   (ADDR_BITS),
    .INSTR_BITS  (INSTR_BITS),
    .CACHE_LINES (CACHE_LINES)
  ) u_icache (
    .clk         (clk),
    .reset       (reset),
    .lookup_addr (current_pc),
    .hit         (cache_hit),
    .hit_data    (cache_hit_data),
    .fill_en     (fill_en),
    .fill_addr   (mem_read_address),
    .fill_data   (mem_read_data),
    .flush       (cache_flush)
  );
`else
  logic unused_cache_sigs;
  assign unused_cache_sigs = cache_flush ^ fill_en;
  assign cache_hit         = 1'b0;
  assign cache_hit_data    = '0;
`endif

  assign fetcher_state = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      instruction      <= '0;
    end else begin
      state_q          <= state_d;
      mem_read_valid   <= valid_d;
      mem_read_address <= addr_d;
      instruction      <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = mem_read_valid;
    addr_d  = mem_read_address;
    instr_d = instruction;
    fill_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (core_state == CORE_FETCH) begin
          if (cache_hit) begin
            instr_d = cache_hit_data;
            state_d = FETCHED;
          end else begin
            addr_d  = current_pc;
            valid_d = 1'b1;
            state_d = FETCHING;
          end
        end
      end
      // core_state is deliberately ignored until memory answers.
      FETCHING: begin
        if (mem_read_ready) begin
          instr_d = mem_read_data;
          valid_d = 1'b0;
          fill_en = 1'b1;
          state_d = FETCHED;
        end
      end
      FETCHED: begin
        if (core_state == CORE_DECODE) begin
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetcher.sv
// tb/tb_instr_fetcher.sv - self-checking bench for instr_fetcher against a line-table cache model
module tb_instr_fetcher;

  localparam int CL = 8;
`ifdef INSTR_FETCHER_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  core_state = 3'b000;
  logic [7:0]  current_pc = 8'h00;
  logic        cache_flush = 1'b0;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready = 1'b0;
  logic [15:0] mem_read_data = 16'h0000;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;

  int n_checks = 0;
  int n_fail   = 0;

  bit          m_valid [CL];
  logic [7:0]  m_pc    [CL];
  logic [15:0] m_data  [CL];
  logic [15:0] exp_instr = 16'h0000;

  always #5 clk = ~clk;

  instr_fetcher #(
    .ADDR_BITS   (8),
    .INSTR_BITS  (16),
    .CACHE_LINES (CL)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .core_state       (core_state),
    .current_pc       (current_pc),
    .cache_flush      (cache_flush),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .fetcher_state    (fetcher_state),
    .instruction      (instruction)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hit(input logic [7:0] pc, input bit fl);
    int idx;
    idx = int'(pc) % CL;
    return CACHE_ON && !fl && m_valid[idx] && (m_pc[idx] == pc);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < CL; i++) m_valid[i] = 1'b0;
  endtask

  task automatic m_fill(input logic [7:0] pc, input logic [15:0] d);
    int idx;
    idx = int'(pc) % CL;
    m_valid[idx] = 1'b1;
    m_pc[idx]    = pc;
    m_data[idx]  = d;
  endtask

  // One complete FETCH..DECODE transaction; memory answers after `delay` stalled cycles.
  task automatic do_fetch(input logic [7:0] pc, input logic [15:0] d, input int delay,
                          input bit flush_fill, input bit flush_lookup, input int hold);
    bit hit;
    hit = m_hit(pc, flush_lookup);
    core_state     = 3'b001;
    current_pc     = pc;
    cache_flush    = flush_lookup;
    mem_read_ready = 1'($urandom_range(0, 1));
    mem_read_data  = 16'($urandom);
    tick();
    cache_flush = 1'b0;
    if (flush_lookup) m_clear();
    if (hit) begin
      exp_instr = m_data[int'(pc) % CL];
      chk("hit_state", 32'(fetcher_state), 32'd2);
      chk("hit_no_valid", 32'(mem_read_valid), 32'd0);
      chk("hit_instr", 32'(instruction), 32'(exp_instr));
    end else begin
      chk("miss_state", 32'(fetcher_state), 32'd1);
      chk("miss_valid", 32'(mem_read_valid), 32'd1);
      chk("miss_addr", 32'(mem_read_address), 32'(pc));
      for (int i = 0; i < delay; i++) begin
        core_state     = 3'($urandom_range(0, 7));
        current_pc     = 8'($urandom);
        mem_read_ready = 1'b0;
        mem_read_data  = 16'($urandom);
        tick();
        chk("stall_state", 32'(fetcher_state), 32'd1);
        chk("stall_valid", 32'(mem_read_valid), 32'd1);
        chk("stall_addr", 32'(mem_read_address), 32'(pc));
      end
      mem_read_ready = 1'b1;
      mem_read_data  = d;
      cache_flush    = flush_fill;
      tick();
      mem_read_ready = 1'b0;
      cache_flush    = 1'b0;
      exp_instr      = d;
      if (flush_fill) m_clear();
      else m_fill(pc, d);
      chk("fill_state", 32'(fetcher_state), 32'd2);
      chk("fill_valid", 32'(mem_read_valid), 32'd0);
      chk("fill_instr", 32'(instruction), 32'(exp_instr));
    end
    for (int i = 0; i < hold; i++) begin
      core_state     = 3'b001;
      current_pc     = 8'($urandom);
      mem_read_ready = 1'($urandom_range(0, 1));
      tick();
      chk("hold_state", 32'(fetcher_state), 32'd2);
      chk("hold_valid", 32'(mem_read_valid), 32'd0);
      chk("hold_instr", 32'(instruction), 32'(exp_instr));
    end
    core_state     = 3'b010;
    mem_read_ready = 1'b0;
    tick();
    chk("decode_state", 32'(fetcher_state), 32'd0);
    chk("decode_instr", 32'(instruction), 32'(exp_instr));
    chk("decode_valid", 32'(mem_read_valid), 32'd0);
    core_state = 3'b000;
  endtask

  initial begin
    m_clear();
    tick();
    tick();
    chk("rst_state", 32'(fetcher_state), 32'd0);
    chk("rst_valid", 32'(mem_read_valid), 32'd0);
    chk("rst_addr", 32'(mem_read_address), 32'd0);
    chk("rst_instr", 32'(instruction), 32'd0);
    reset = 1'b0;

    // Cache a line, then abandon a request with reset; the line must be gone afterwards.
    do_fetch(8'h11, 16'hABCD, 0, 1'b0, 1'b0, 0);
    core_state = 3'b001;
    current_pc = 8'h33;
    tick();
    chk("pre_rst_valid", 32'(mem_read_valid), 32'd1);
    core_state = 3'b000;
    reset      = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(mem_read_valid), 32'd0);
    chk("mid_rst_state", 32'(fetcher_state), 32'd0);
    chk("mid_rst_instr", 32'(instruction), 32'd0);
    tick();
    reset = 1'b0;
    m_clear();
    exp_instr = 16'h0000;
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("late_ready_state", 32'(fetcher_state), 32'd0);
      chk("late_ready_valid", 32'(mem_read_valid), 32'd0);
      chk("late_ready_instr", 32'(instruction), 32'd0);
    end
    mem_read_ready = 1'b0;
    do_fetch(8'h11, 16'h1111, 1, 1'b0, 1'b0, 0);

    do_fetch(8'h05, 16'h9104, 3, 1'b0, 1'b0, 0);
    do_fetch(8'h03, 16'h7210, 0, 1'b0, 1'b0, 0);
    do_fetch(8'h03, 16'h7210, 0, 1'b0, 1'b0, 0);
    do_fetch(8'h02, 16'h2222, 1, 1'b0, 1'b0, 0);
    do_fetch(8'h0A, 16'hAAAA, 0, 1'b0, 1'b0, 0);
    do_fetch(8'h02, 16'h2223, 2, 1'b0, 1'b0, 0);
    do_fetch(8'h04, 16'h4444, 0, 1'b1, 1'b0, 0);
    do_fetch(8'h04, 16'h4445, 0, 1'b0, 1'b0, 0);
    do_fetch(8'h04, 16'h4446, 0, 1'b0, 1'b1, 0);
    do_fetch(8'h07, 16'h7777, 1, 1'b0, 1'b0, 3);
    do_fetch(8'h07, 16'h7777, 0, 1'b0, 1'b0, 3);

    for (int n = 0; n < 60; n++) begin
      do_fetch(8'($urandom_range(0, 23)), 16'($urandom), $urandom_range(0, 3),
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
               $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
